// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered EX-stage ALU with iterative multiply and divide.
//
// Single-cycle operations (add/sub/logic/compare/shift) register their result
// on the start edge and pulse done in the following cycle. Unsigned multiply
// (shift-add, LSB first) and unsigned divide (restoring, MSB first) iterate
// one bit per clock; busy is high while they run and start is ignored.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             request, accepted only when busy=0 (IDLE or DONE)
//   a, b              operands, sampled on the accepting edge only
//   sig_alu_control   4-bit opcode, sampled with start
//   busy              multi-cycle operation in progress
//   done              one-cycle completion pulse
//   result            main result / product low half / quotient
//   result_hi         product high half / remainder, 0 for other ops
//   sig_zero          result == 0
//   sig_overflow      signed overflow of add/sub
//   sig_div_zero      last completed op was divu with b == 0
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sig_alu_control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             sig_zero,
    output logic             sig_overflow,
    output logic             sig_div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Shared iteration registers: {acc, lo} is the product for mul;
    // acc is the partial remainder and lo the dividend/quotient for divu.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;

    logic             can_start;
    logic             last_step;
    logic [WIDTH-1:0] simple_res;
    logic             simple_ovf;
    logic [WIDTH-1:0] sum_ab, diff_ab;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_take;
    logic [WIDTH-1:0] div_rem, div_quo, mul_lo;

    assign can_start = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_step = (cnt_q == CW'(1));

    // ---------------- state register ----------------
    // NOTE: reset is sampled inside the clocked block (synchronous), and all
    // sequential state uses non-blocking assignment so every flop sees the
    // pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (can_start) begin
                    if (sig_alu_control == OP_MUL)       state_d = S_MUL;
                    else if (sig_alu_control == OP_DIVU) state_d = S_DIV;
                    else                                 state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: if (last_step) state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_DIV);
        done = (state_q == S_DONE);
    end

    assign result       = result_q;
    assign result_hi    = result_hi_q;
    assign sig_zero     = zero_q;
    assign sig_overflow = ovf_q;
    assign sig_div_zero = dz_q;

    // ---------------- single-cycle operations ----------------
    assign sum_ab  = a + b;
    assign diff_ab = a - b;
    assign shamt   = b[SHW-1:0];

    always_comb begin
        simple_ovf = 1'b0;
        unique case (sig_alu_control)
            OP_SUB: begin
                simple_res = diff_ab;
                simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  simple_res = a ^ b;
            OP_NOR:  simple_res = ~(a | b);
            OP_SLL:  simple_res = a << shamt;
            OP_SRL:  simple_res = a >> shamt;
            OP_SRA:  simple_res = $signed(a) >>> shamt;
            default: begin
                // add, and the unused codes that alias to add
                simple_res = sum_ab;
                simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

    // ---------------- iteration steps ----------------
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring step. A zero divisor always "subtracts", which drives the
    // quotient to all ones and shifts the dividend unchanged into the
    // remainder -- exactly the required divide-by-zero outputs.
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_take  = !div_diff[WIDTH] || (opnd_q == '0);
    assign div_rem   = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {lo_q[WIDTH-2:0], div_take};

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (can_start) begin
                    if (sig_alu_control == OP_MUL || sig_alu_control == OP_DIVU) begin
                        acc_d  = '0;
                        lo_d   = a;
                        opnd_d = b;
                        cnt_d  = CW'(WIDTH);
                    end else begin
                        result_d    = simple_res;
                        result_hi_d = '0;
                        zero_d      = (simple_res == '0);
                        ovf_d       = simple_ovf;
                        dz_d        = 1'b0;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                lo_d  = mul_lo;
                cnt_d = cnt_q - CW'(1);
                if (last_step) begin
                    result_d    = mul_lo;
                    result_hi_d = mul_sum[WIDTH:1];
                    zero_d      = (mul_lo == '0);
                    ovf_d       = 1'b0;
                    dz_d        = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                lo_d  = div_quo;
                cnt_d = cnt_q - CW'(1);
                if (last_step) begin
                    result_d    = div_quo;
                    result_hi_d = div_rem;
                    zero_d      = (div_quo == '0);
                    ovf_d       = 1'b0;
                    dz_d        = (opnd_q == '0);
                end
            end
            default: ;
        endcase
    end

endmodule
